bkm_steps_ctrl: RTL and testbench

- Sequencer for the bkm_steps iteration datapath.
- Accepts a start request with mode/format and latches the configuration.
- Issues one load strobe, then 2^LOG2N step strobes with the step index, drains the datapath pipeline, and pulses done.
- Sits between the FPU BKM front-end (start/mode/format source) and the bkm_steps datapath; its done is the res_done seen by the checker.

---
 rtl/bkm_steps_ctrl_if.sv | 41 ++++
 rtl/bkm_steps_ctrl.sv | 150 +++++++++++++++
 tb/tb_bkm_steps_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bkm_steps_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : bkm_steps_ctrl_if
//  Brief    : Control/strobe bundle between the BKM front-end, the sequencer
//             and the bkm_steps datapath.
//  Revision : 1.0 - initial release
// ============================================================================
interface bkm_steps_ctrl_if #(
    parameter int LOG2N = 6
);
    logic             enable;
    logic             start;
    logic             abort;
    logic             mode;
    logic [1:0]       format;
    logic             busy;
    logic             load;
    logic             step_en;
    logic [LOG2N-1:0] step_n;
    logic             last_step;
    logic             mode_q;
    logic [1:0]       format_q;
    logic             done;
    logic             aborted;
    logic             start_drop;
    logic [15:0]      op_cnt;
    logic [15:0]      drop_cnt;

    modport master (
        output enable, start, abort, mode, format,
        input  busy, load, step_en, step_n, last_step, mode_q, format_q,
               done, aborted, start_drop, op_cnt, drop_cnt
    );

    modport slave (
        input  enable, start, abort, mode, format,
        output busy, load, step_en, step_n, last_step, mode_q, format_q,
               done, aborted, start_drop, op_cnt, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bkm_steps_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bkm_steps_ctrl
//  Brief    : Sequencer for the bkm_steps datapath: load, 2^LOG2N steps,
//             pipeline drain, done. BKM_STEPS_CTRL_STATS_EN builds op/drop
//             statistics counters.
//  Revision : 1.0 - initial release
// ============================================================================
module bkm_steps_ctrl #(
    parameter int LOG2N    = 6,
    parameter int STEP_LAT = 1
) (
    input wire               clk,
    input wire               srst,
    bkm_steps_ctrl_if.slave  bus
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_ITER  = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic [LOG2N-1:0] c_LAST_STEP = {LOG2N{1'b1}};
    localparam logic [3:0]       c_WAIT_LAST = 4'(STEP_LAT - 1);

    logic [2:0]       r_state;
    logic [LOG2N-1:0] r_step;
    logic [3:0]       r_wait;
    logic             r_aborted;
    logic             r_mode;
    logic [1:0]       r_format;
    logic             r_drop;

    logic w_busy;
    logic w_slot_end;
    logic w_step_en;
    logic w_drop_evt;

    assign w_busy     = (r_state == c_ST_LOAD) || (r_state == c_ST_ITER) ||
                        (r_state == c_ST_DRAIN);
    assign w_slot_end = (r_wait == c_WAIT_LAST);
    assign w_drop_evt = bus.enable && bus.start && (r_state != c_ST_IDLE);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state   <= c_ST_IDLE;
            r_step    <= '0;
            r_wait    <= '0;
            r_aborted <= 1'b0;
            r_mode    <= 1'b0;
            r_format  <= 2'b00;
            r_drop    <= 1'b0;
        end else if (bus.enable) begin
            r_aborted <= 1'b0;
            if (w_drop_evt) begin
                r_drop <= 1'b1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_state  <= c_ST_LOAD;
                        r_mode   <= bus.mode;
                        r_format <= bus.format;
                        r_drop   <= 1'b0;
                    end
                end
                c_ST_LOAD: begin
                    r_state <= c_ST_ITER;
                    r_step  <= '0;
                    r_wait  <= '0;
                end
                c_ST_ITER: begin
                    if (w_slot_end) begin
                        r_wait <= '0;
                        if (r_step == c_LAST_STEP) begin
                            r_state <= c_ST_DRAIN;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                c_ST_DRAIN: begin
                    if (w_slot_end) begin
                        r_state <= c_ST_DONE;
                        r_step  <= '0;
                        r_wait  <= '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
            // Abort overrides whatever the active state would have done.
            if (bus.abort && w_busy) begin
                r_state   <= c_ST_IDLE;
                r_step    <= '0;
                r_wait    <= '0;
                r_aborted <= 1'b1;
            end
        end
    end

    // Strobes are gated by enable so a frozen cycle re-issues them later.
    assign w_step_en     = bus.enable && (r_state == c_ST_ITER) && (r_wait == 4'd0);
    assign bus.busy      = w_busy;
    assign bus.load      = bus.enable && (r_state == c_ST_LOAD);
    assign bus.step_en   = w_step_en;
    assign bus.step_n    = w_step_en ? r_step : '0;
    assign bus.last_step = w_step_en && (r_step == c_LAST_STEP);
    assign bus.done      = bus.enable && (r_state == c_ST_DONE);
    assign bus.aborted   = bus.enable && r_aborted;
    assign bus.mode_q    = r_mode;
    assign bus.format_q  = r_format;
    assign bus.start_drop = r_drop;

`ifdef BKM_STEPS_CTRL_STATS_EN
    logic [15:0] r_op_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_op_cnt   <= 16'd0;
            r_drop_cnt <= 16'd0;
        end else if (bus.enable) begin
            if ((r_state == c_ST_DONE) && (r_op_cnt != 16'hFFFF)) begin
                r_op_cnt <= r_op_cnt + 16'd1;
            end
            if (w_drop_evt && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign bus.op_cnt   = r_op_cnt;
    assign bus.drop_cnt = r_drop_cnt;
`else
    assign bus.op_cnt   = 16'd0;
    assign bus.drop_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bkm_steps_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bkm_steps_ctrl
//  Brief    : Directed vectors for bkm_steps_ctrl (N=64/LAT=1 and N=4/LAT=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bkm_steps_ctrl;

    localparam int DONE_CYC = 2 + 64 * 1 + 1;
    localparam int LAST_CYC = 2 + 63;

    typedef struct {
        logic       mode;
        logic [1:0] fmt;
        int         abort_at;
        int         frz_at;
        int         frz_len;
        int         drop1;
        int         drop2;
        int         run_cycles;
        int         exp_done;
        logic       exp_drop;
    } vec_t;

    logic clk;
    logic srst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_ops = 0;
    int   exp_drops = 0;

    bkm_steps_ctrl_if #(.LOG2N(6)) bus ();
    bkm_steps_ctrl_if #(.LOG2N(2)) bus3 ();

    bkm_steps_ctrl #(.LOG2N(6), .STEP_LAT(1)) dut (
        .clk (clk),
        .srst(srst),
        .bus (bus)
    );

    bkm_steps_ctrl #(.LOG2N(2), .STEP_LAT(3)) dut3 (
        .clk (clk),
        .srst(srst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_stats(input string name);
`ifdef BKM_STEPS_CTRL_STATS_EN
        chk({name, " op_cnt"},   {16'd0, bus.op_cnt},   32'(exp_ops));
        chk({name, " drop_cnt"}, {16'd0, bus.drop_cnt}, 32'(exp_drops));
`else
        chk({name, " op_cnt"},   {16'd0, bus.op_cnt},   32'd0);
        chk({name, " drop_cnt"}, {16'd0, bus.drop_cnt}, 32'd0);
`endif
    endtask

    function automatic logic [15:0] pack_main();
        return {bus.busy, bus.load, bus.step_en, bus.step_n, bus.last_step,
                bus.done, bus.aborted, bus.start_drop, bus.mode_q, bus.format_q};
    endfunction

    task automatic run_vec(input int idx, input vec_t v, output int obs_done);
        int         e;
        bit         frz;
        logic       ex_busy, ex_load, ex_step, ex_last, ex_done, ex_ab, ex_drop;
        logic [5:0] ex_sn;
        logic [15:0] exp;
        bus.start  = 1'b1;
        bus.abort  = 1'b0;
        bus.enable = 1'b1;
        bus.mode   = v.mode;
        bus.format = v.fmt;
        @(posedge clk); #1;
        bus.mode   = ~v.mode;
        bus.format = ~v.fmt;
        obs_done   = 0;
        for (int c = 1; c <= v.run_cycles; c++) begin
            frz = (v.frz_at >= 0) && (c >= v.frz_at) && (c < v.frz_at + v.frz_len);
            if (v.frz_at >= 0 && c >= v.frz_at + v.frz_len) e = c - v.frz_len;
            else if (frz)                                     e = v.frz_at;
            else                                              e = c;
            bus.start  = (c == v.drop1) || (c == v.drop2);
            bus.abort  = (c == v.abort_at);
            bus.enable = !frz;
            ex_busy = (e >= 1) && (e < DONE_CYC);
            ex_load = !frz && (e == 1);
            ex_step = !frz && (e >= 2) && (e <= LAST_CYC);
            ex_sn   = ex_step ? 6'(e - 2) : 6'd0;
            ex_last = ex_step && (e == LAST_CYC);
            ex_done = !frz && (e == DONE_CYC);
            ex_ab   = 1'b0;
            ex_drop = (v.drop1 >= 0 && c > v.drop1) || (v.drop2 >= 0 && c > v.drop2);
            if (v.abort_at >= 0 && c > v.abort_at) begin
                {ex_busy, ex_load, ex_step, ex_last, ex_done} = '0;
                ex_sn = 6'd0;
                ex_ab = (c == v.abort_at + 1);
            end
            exp = {ex_busy, ex_load, ex_step, ex_sn, ex_last, ex_done, ex_ab,
                   ex_drop, v.mode, v.fmt};
            @(negedge clk);
            chk($sformatf("vec%0d cyc%0d outputs", idx, c), {16'd0, pack_main()}, {16'd0, exp});
            if (bus.done && obs_done == 0) obs_done = c;
            @(posedge clk); #1;
        end
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.enable = 1'b1;
    endtask

    initial begin
        vec_t vecs[5];
        int   obs;
        logic prev_step;
        logic [6:0] exp3;

        // mode fmt abort frz_at frz_len drop1 drop2 run exp_done exp_drop
        vecs[0] = '{1'b1, 2'b10, -1, -1, 0, -1, -1, 67, 67, 1'b0};
        vecs[1] = '{1'b0, 2'b01, 12, -1, 0, -1, -1, 13,  0, 1'b0};
        vecs[2] = '{1'b1, 2'b11, -1, -1, 0, -1, -1, 70, 67, 1'b0};
        vecs[3] = '{1'b0, 2'b00, -1, -1, 0,  5, 30, 70, 67, 1'b1};
        vecs[4] = '{1'b1, 2'b01, -1, 22, 4, -1, -1, 74, 71, 1'b0};

        srst = 1'b1;
        bus.enable = 1'b1;  bus.start = 1'b0;  bus.abort = 1'b0;
        bus.mode   = 1'b0;  bus.format = 2'b00;
        bus3.enable = 1'b1; bus3.start = 1'b0; bus3.abort = 1'b0;
        bus3.mode   = 1'b0; bus3.format = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset outputs", {16'd0, pack_main()}, 32'd0);
        chk_stats("reset");
        chk("reset dut3", {25'd0, bus3.busy, bus3.load, bus3.step_en, bus3.step_n,
                           bus3.done, bus3.aborted}, 32'd0);
        @(posedge clk); #1;
        srst = 1'b0;

        foreach (vecs[i]) begin
            run_vec(i, vecs[i], obs);
            chk($sformatf("vec%0d done cycle", i), 32'(obs), 32'(vecs[i].exp_done));
            chk($sformatf("vec%0d start_drop", i), {31'd0, bus.start_drop}, {31'd0, vecs[i].exp_drop});
            if (vecs[i].exp_done != 0) exp_ops++;
            exp_drops += (vecs[i].drop1 >= 0 ? 1 : 0) + (vecs[i].drop2 >= 0 ? 1 : 0);
            chk_stats($sformatf("vec%0d", i));
        end

        // N=4, STEP_LAT=3 instance: steps at 2,5,8,11, done at 17
        bus3.start = 1'b1; bus3.mode = 1'b1; bus3.format = 2'b10;
        @(posedge clk); #1;
        bus3.start = 1'b0;
        prev_step  = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            exp3 = {(c >= 1 && c < 17), (c == 1),
                    (c == 2 || c == 5 || c == 8 || c == 11),
                    (c >= 2 && c <= 11 && (c - 2) % 3 == 0) ? 2'((c - 2) / 3) : 2'd0,
                    (c == 11), (c == 17)};
            @(negedge clk);
            chk($sformatf("lat3 cyc%0d", c),
                {25'd0, bus3.busy, bus3.load, bus3.step_en, bus3.step_n,
                 bus3.last_step, bus3.done}, {25'd0, exp3});
            chk($sformatf("lat3 cyc%0d no b2b step", c), {31'd0, prev_step && bus3.step_en}, 32'd0);
            prev_step = bus3.step_en;
            @(posedge clk); #1;
        end
        chk("lat3 cfg", {29'd0, bus3.mode_q, bus3.format_q}, {29'd0, 1'b1, 2'b10});

        // srst at step_n=40 with a pending start_drop
        bus.start = 1'b1; bus.mode = 1'b1; bus.format = 2'b10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 42; c++) begin
            bus.start = (c == 10);
            @(negedge clk);
            if (c == 42) begin
                chk("pre-srst step_n", {26'd0, bus.step_n}, 32'd40);
                chk("pre-srst start_drop", {31'd0, bus.start_drop}, 32'd1);
                srst = 1'b1;
            end
            @(posedge clk); #1;
        end
        srst = 1'b0;
        bus.start = 1'b0;
        exp_ops = 0;
        exp_drops = 0;
        @(negedge clk);
        chk("post-srst outputs", {16'd0, pack_main()}, 32'd0);
        chk_stats("post-srst");
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("post-srst idle%0d", c), {29'd0, bus.busy, bus.done, bus.aborted}, 32'd0);
        end

        // start with abort in IDLE: not accepted
        @(posedge clk); #1;
        bus.start = 1'b1; bus.abort = 1'b1; bus.mode = 1'b1; bus.format = 2'b11;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("start+abort idle%0d", c), {16'd0, pack_main()}, 32'd0);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
